// File: rtl/motor_drive_ctrl.sv
`timescale 1ns/1ps
// motor_drive_ctrl: turns the tracker's 2-bit command into per-wheel PWM and
// H-bridge direction. A dwell timer keeps turn commands from chattering.
// Wheel duties ramp toward their targets once per PWM period. Stop drops both
// duties to zero at once.
module motor_drive_ctrl #(
    parameter int PWM_PERIOD  = 1000,
    parameter int DUTY_W      = 10,
    parameter int DUTY_FAST   = 800,
    parameter int DUTY_SLOW   = 300,
    parameter int RAMP_STEP   = 50,
    parameter int HOLD_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_motor,
    output logic [1:0] right_motor,
    output logic [1:0] cmd_active
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DUTY_W-1:0] CNT_MAX  = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [DUTY_W-1:0] CNT_ONE  = DUTY_W'(1);
    localparam logic [DUTY_W-1:0] D_FAST   = DUTY_W'(DUTY_FAST);
    localparam logic [DUTY_W-1:0] D_SLOW   = DUTY_W'(DUTY_SLOW);
    localparam logic [DUTY_W-1:0] D_STEP   = DUTY_W'(RAMP_STEP);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    // The applied command is the only FSM state; cmd_active exposes it directly.
    typedef enum logic [1:0] {
        CMD_LEFT     = 2'b00,
        CMD_RIGHT    = 2'b01,
        CMD_STRAIGHT = 2'b10,
        CMD_STOP     = 2'b11
    } cmd_e;

    cmd_e              cmd_q, cmd_d, state_cmd;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [DUTY_W-1:0] ldut_q, ldut_d, rdut_q, rdut_d;
    logic [DUTY_W-1:0] ltgt, rtgt;
    logic              lpwm_q, lpwm_d, rpwm_q, rpwm_d;
    logic              boundary;

    assign state_cmd = cmd_e'(state);

    // Move one step toward the target, landing exactly on it and never
    // wrapping below zero.
    function automatic logic [DUTY_W-1:0] ramp(input logic [DUTY_W-1:0] cur,
                                               input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W-1:0] nxt;
        nxt = cur;
        if (tgt > cur) begin
            nxt = (tgt - cur > D_STEP) ? cur + D_STEP : tgt;
        end else if (cur > tgt) begin
            nxt = (cur - tgt > D_STEP) ? cur - D_STEP : tgt;
        end
        return nxt;
    endfunction

    // State register for command, dwell timer, PWM counter, duties and PWM pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q  <= CMD_STOP;
            hold_q <= HOLD_MAX;
            cnt_q  <= '0;
            ldut_q <= '0;
            rdut_q <= '0;
            lpwm_q <= 1'b0;
            rpwm_q <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
            ldut_q <= ldut_d;
            rdut_q <= rdut_d;
            lpwm_q <= lpwm_d;
            rpwm_q <= rpwm_d;
        end
    end

    // Command acceptance: stop pre-empts the dwell timer. Any other change
    // waits for the timer to saturate and then restarts it.
    always_comb begin
        cmd_d  = cmd_q;
        hold_d = hold_q;
        if (state_cmd == CMD_STOP && cmd_q != CMD_STOP) begin
            cmd_d  = CMD_STOP;
            hold_d = '0;
        end else if (state_cmd != cmd_q && hold_q >= HOLD_MAX) begin
            cmd_d  = state_cmd;
            hold_d = '0;
        end else if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
        end
    end

    // Per-wheel duty targets for the command currently applied.
    always_comb begin
        ltgt = '0;
        rtgt = '0;
        case (cmd_q)
            CMD_LEFT:     begin ltgt = D_SLOW; rtgt = D_FAST; end
            CMD_RIGHT:    begin ltgt = D_FAST; rtgt = D_SLOW; end
            CMD_STRAIGHT: begin ltgt = D_FAST; rtgt = D_FAST; end
            default:      begin ltgt = '0;     rtgt = '0;     end
        endcase
    end

    // PWM counter, duty update (ramp only on the wrap cycle, stop forces zero),
    // and PWM compare. The compare uses next-state values, so the registered
    // pin always matches the counter and duty held in the same cycle.
    always_comb begin
        boundary = (cnt_q == CNT_MAX);
        cnt_d    = boundary ? '0 : cnt_q + CNT_ONE;
        ldut_d   = ldut_q;
        rdut_d   = rdut_q;
        if (cmd_q == CMD_STOP) begin
            ldut_d = '0;
            rdut_d = '0;
        end else if (boundary) begin
            ldut_d = ramp(ldut_q, ltgt);
            rdut_d = ramp(rdut_q, rtgt);
        end
        lpwm_d = (cnt_d < ldut_d);
        rpwm_d = (cnt_d < rdut_d);
    end

    assign left_pwm    = lpwm_q;
    assign right_pwm   = rpwm_q;
    assign left_motor  = (ldut_q != '0) ? 2'b10 : 2'b00;
    assign right_motor = (rdut_q != '0) ? 2'b10 : 2'b00;
    assign cmd_active  = cmd_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
`timescale 1ns/1ps
// Bench for motor_drive_ctrl. Directed command sequences with hand-computed
// window counts, plus an arithmetic model compared on every falling edge.
module tb_motor_drive_ctrl;

    localparam int P     = 10;
    localparam int FAST  = 8;
    localparam int SLOW  = 4;
    localparam int STEP  = 2;
    localparam int HOLD  = 20;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [1:0] st_i = 2'b11;
    logic       left_pwm, right_pwm;
    logic [1:0] left_motor, right_motor, cmd_active;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Model state: what the DUT should show in the current cycle.
    int         m_phase, m_ld, m_rd, m_age;
    logic [1:0] m_cmd;

    motor_drive_ctrl #(
        .PWM_PERIOD(P), .DUTY_W(4), .DUTY_FAST(FAST), .DUTY_SLOW(SLOW),
        .RAMP_STEP(STEP), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .reset(rst_i), .state(st_i),
        .left_pwm(left_pwm), .right_pwm(right_pwm),
        .left_motor(left_motor), .right_motor(right_motor),
        .cmd_active(cmd_active)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int tgt_l(input logic [1:0] c);
        case (c)
            2'b00:   return SLOW;
            2'b01:   return FAST;
            2'b10:   return FAST;
            default: return 0;
        endcase
    endfunction

    function automatic int tgt_r(input logic [1:0] c);
        case (c)
            2'b00:   return FAST;
            2'b01:   return SLOW;
            2'b10:   return FAST;
            default: return 0;
        endcase
    endfunction

    function automatic int approach(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (d > STEP) d = STEP;
        if (d < -STEP) d = -STEP;
        return cur + d;
    endfunction

    // Advance the model across one clock edge given the inputs present at it.
    task automatic model_step(input logic r, input logic [1:0] s);
        logic [1:0] nxt;
        bit acc;
        if (r) begin
            m_cmd = 2'b11; m_age = HOLD; m_phase = 0; m_ld = 0; m_rd = 0;
        end else begin
            nxt = m_cmd;
            acc = 1'b0;
            if (s == 2'b11 && m_cmd != 2'b11) begin
                nxt = 2'b11; acc = 1'b1;
            end else if (s != m_cmd && m_age >= HOLD) begin
                nxt = s; acc = 1'b1;
            end
            if (m_cmd == 2'b11) begin
                m_ld = 0; m_rd = 0;
            end else if (m_phase == P - 1) begin
                m_ld = approach(m_ld, tgt_l(m_cmd));
                m_rd = approach(m_rd, tgt_r(m_cmd));
            end
            m_phase = (m_phase + 1) % P;
            m_age   = acc ? 0 : m_age + 1;
            m_cmd   = nxt;
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_active",  int'(cmd_active),  int'(m_cmd));
            chk("left_pwm",    int'(left_pwm),    (m_phase < m_ld) ? 1 : 0);
            chk("right_pwm",   int'(right_pwm),   (m_phase < m_rd) ? 1 : 0);
            chk("left_motor",  int'(left_motor),  (m_ld > 0) ? 2 : 0);
            chk("right_motor", int'(right_motor), (m_rd > 0) ? 2 : 0);
        end
    end

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic cycle(input logic r, input logic [1:0] s);
        rst_i = r;
        st_i  = s;
        @(posedge clk);
        #1;
        model_step(r, s);
        if (r) cyc = 0; else cyc++;
    endtask

    task automatic run(input int n, input logic [1:0] s);
        for (int i = 0; i < n; i++) cycle(1'b0, s);
    endtask

    // Run until the next cycle starts a new PWM period.
    task automatic align(input logic [1:0] s);
        while (cyc % P != P - 1) cycle(1'b0, s);
    endtask

    task automatic run_window(input logic [1:0] s, output int lh, output int rh,
                              output logic [9:0] pat);
        lh = 0; rh = 0; pat = '0;
        for (int i = 0; i < P; i++) begin
            cycle(1'b0, s);
            lh += int'(left_pwm);
            rh += int'(right_pwm);
            pat[i] = left_pwm;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lh, rh, kept;
        logic [9:0] pat;
        int up_exp[5];
        up_exp = '{2, 4, 6, 8, 8};

        // Reset state
        cycle(1'b1, 2'b11);
        cycle(1'b1, 2'b11);
        chk_en = 1'b1;
        chk("rst_cmd", int'(cmd_active), 3);
        chk("rst_pwm", int'({left_pwm, right_pwm}), 0);
        chk("rst_motor", int'({left_motor, right_motor}), 0);

        // Straight from reset: accepted next cycle, ramps 2/4/6/8 per period
        cycle(1'b0, 2'b10);
        chk("straight_accept", int'(cmd_active), 2);
        run(8, 2'b10);
        for (int k = 0; k < 5; k++) begin
            run_window(2'b10, lh, rh, pat);
            chk($sformatf("ramp_up_l_w%0d", k), lh, up_exp[k]);
            chk($sformatf("ramp_up_r_w%0d", k), rh, up_exp[k]);
        end
        chk("steady_pattern", int'(pat), 10'h0FF);
        chk("steady_motors", int'({left_motor, right_motor}), 4'b1010);

        // Turn left after the hold has expired: left ramps 8->6->4, right stays 8
        cycle(1'b0, 2'b00);
        chk("left_accept", int'(cmd_active), 0);
        align(2'b00);
        run_window(2'b00, lh, rh, pat);
        chk("turnl_w0_l", lh, 6);
        run_window(2'b00, lh, rh, pat);
        chk("turnl_w1_l", lh, 4);
        run_window(2'b00, lh, rh, pat);
        chk("turnl_w2_l", lh, 4);
        chk("turnl_w2_r", rh, 8);

        // Fresh turn_left acceptance, then toggle 01/00 every 3 cycles
        cycle(1'b0, 2'b01);
        chk("right_accept", int'(cmd_active), 1);
        run(20, 2'b01);
        cycle(1'b0, 2'b00);
        chk("left_reaccept", int'(cmd_active), 0);
        kept = 0;
        for (int j = 1; j <= 20; j++) begin
            cycle(1'b0, (((j - 1) / 3) % 2 == 0) ? 2'b01 : 2'b00);
            if (cmd_active == 2'b00) kept++;
        end
        chk("toggle_hold_kept", kept, 20);
        cycle(1'b0, 2'b01);
        chk("toggle_expiry_take", int'(cmd_active), 1);

        // Stop while the hold is far from expired
        run(3, 2'b01);
        chk("prestop_motors", int'({left_motor, right_motor}), 4'b1010);
        cycle(1'b0, 2'b11);
        chk("stop_accept", int'(cmd_active), 3);
        cycle(1'b0, 2'b11);
        chk("stop_pwm_low", int'({left_pwm, right_pwm}), 0);
        chk("stop_motors", int'({left_motor, right_motor}), 0);

        // Stop held past the hold, then straight ramps up from zero
        run(25, 2'b11);
        align(2'b11);
        cycle(1'b0, 2'b10);
        chk("leave_stop", int'(cmd_active), 2);
        run(9, 2'b10);
        run_window(2'b10, lh, rh, pat);
        chk("reramp_w0", lh, 2);
        run_window(2'b10, lh, rh, pat);
        chk("reramp_w1", lh, 4);
        run_window(2'b10, lh, rh, pat);
        chk("reramp_w2", lh, 6);

        // Reset mid-ramp while left_pwm is high
        run(3, 2'b10);
        chk("pre_reset_pwm", int'(left_pwm), 1);
        cycle(1'b1, 2'b10);
        chk("midrst_cmd", int'(cmd_active), 3);
        chk("midrst_pwm", int'({left_pwm, right_pwm}), 0);
        chk("midrst_motor", int'({left_motor, right_motor}), 0);
        cycle(1'b0, 2'b10);
        chk("postrst_accept", int'(cmd_active), 2);
        run(8, 2'b10);
        run_window(2'b10, lh, rh, pat);
        chk("postrst_w0_l", lh, 2);
        chk("postrst_w0_r", rh, 2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
